// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle multiply/divide unit with HI/LO registers for the pipelined
//   MIPS core. Operands arrive from the EX stage (rs/rt after forwarding).
//   HI/LO feed the write-back path for mfhi/mflo. Busy/Start feed the hazard
//   unit, which stalls md-class instructions.
//
//   Ports:
//     Clk      in   1   clock, rising edge
//     Reset    in   1   asynchronous, active-high reset
//     Start    in   1   launch mult/multu/div/divu selected by MDOp
//     MDOp     in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//     A        in  32   rs operand (dividend / multiplicand / mthi-mtlo data)
//     B        in  32   rt operand (divisor / multiplier)
//     Busy     out  1   high while an operation is in flight
//     HI       out 32   HI register
//     LO       out 32   LO register
//     DivZero  out  1   one-cycle divide-by-zero flag (guard build only)
//
//   Parameters: MULT_CYCLES, DIV_CYCLES (busy cycles, 1..15).
//
//   Build option MDU_DIV0_GUARD_EN:
//     defined   - DIV/DIVU with B==0 does not launch; DivZero pulses for one
//                 cycle after the launch edge, HI/LO untouched.
//     undefined - DivZero is tied low; divide by zero runs the normal latency
//                 and yields LO=0xFFFFFFFF, HI=A.

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivZero
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state, state_next;
  logic [3:0]         cnt;
  logic [31:0]        res_hi_p0, res_lo_p0;   // result captured at launch
  logic [31:0]        res_hi, res_lo;
  logic               is_md, is_div, launch;
  logic signed [63:0] a_ext_s, b_ext_s, prod_s;
  logic        [63:0] prod_u;

  // Returns {remainder, quotient}. Done on magnitudes so that the
  // 0x80000000 / -1 overflow case wraps to 0x80000000 with remainder 0.
  // Divide by zero yields {A, all-ones}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a, mag_b, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;   // remainder takes the dividend's sign
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  assign a_ext_s = {{32{A[31]}}, A};
  assign b_ext_s = {{32{B[31]}}, B};
  assign prod_s  = a_ext_s * b_ext_s;
  assign prod_u  = {32'd0, A} * {32'd0, B};

  assign is_md  = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
  assign is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);

`ifdef MDU_DIV0_GUARD_EN
  logic div0_try, div_zero_q;
  assign div0_try = Start && (state == S_IDLE) && is_div && (B == 32'd0);
  assign launch   = Start && (state == S_IDLE) && is_md && !div0_try;
`else
  assign launch   = Start && (state == S_IDLE) && is_md;
`endif

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (MDOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   {res_hi, res_lo} = div_signed(A, B);
      OP_DIVU:  {res_hi, res_lo} = div_unsigned(A, B);
      default:  ;
    endcase
  end

  // ---- stage p0: state register ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (launch) state_next = S_BUSY;
      S_BUSY:  if (cnt == 4'd0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == S_BUSY);
  end

  // ---- stage p0: counter, captured result, HI/LO ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      res_hi_p0 <= '0;
      res_lo_p0 <= '0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      if (launch) begin
        cnt       <= is_div ? DIV_LOAD : MULT_LOAD;
        res_hi_p0 <= res_hi;
        res_lo_p0 <= res_lo;
      end else if (state == S_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (state == S_BUSY) begin
        if (cnt == 4'd0) begin
          HI <= res_hi_p0;
          LO <= res_lo_p0;
        end
      end else begin
        // mthi/mtlo only take effect while no op is in flight
        if (MDOp == OP_MTHI) HI <= A;
        if (MDOp == OP_MTLO) LO <= A;
      end
    end
  end

`ifdef MDU_DIV0_GUARD_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) div_zero_q <= 1'b0;
    else       div_zero_q <= div0_try;
  end
  assign DivZero = div_zero_q;
`else
  assign DivZero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed self-checking bench for mult_div_unit with default parameters
//   (MULT_CYCLES=5, DIV_CYCLES=10). Expected values are hand-computed.

module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        Clk, Reset, Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, DivZero;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_errors = 0;

  // bench-side model of the architectural HI/LO
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO),
    .DivZero (DivZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Launch an md op, verify Busy over the whole latency with HI/LO held,
  // then verify the result and update the model.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    Start = 1'b1; MDOp = op; A = a; B = b;
    step();
    Start = 1'b0; MDOp = OP_NONE; A = $urandom; B = $urandom;
    check_val({tag, "_divzero"}, {31'd0, DivZero}, 32'd0);
    for (int k = 0; k < n; k++) begin
      check_val({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      check_val({tag, "_hi_hold"}, HI, m_hi);
      check_val({tag, "_lo_hold"}, LO, m_lo);
      step();
    end
    check_val({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
    check_val({tag, "_hi"}, HI, exp_hi);
    check_val({tag, "_lo"}, LO, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MDOp = OP_NONE; A = '0; B = '0;
    step();
    step();
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_hi", HI, 32'd0);
    check_val("rst_lo", LO, 32'd0);
    check_val("rst_divzero", {31'd0, DivZero}, 32'd0);
    Reset = 1'b0;
    step();

    // mthi then mtlo: single-cycle writes, Busy never asserts
    MDOp = OP_MTHI; A = 32'hDEAD_BEEF;
    step();
    check_val("mthi_busy", {31'd0, Busy}, 32'd0);
    check_val("mthi_hi", HI, 32'hDEAD_BEEF);
    check_val("mthi_lo", LO, 32'd0);
    MDOp = OP_MTLO; A = 32'h0BAD_F00D;
    step();
    check_val("mtlo_busy", {31'd0, Busy}, 32'd0);
    check_val("mtlo_hi", HI, 32'hDEAD_BEEF);
    check_val("mtlo_lo", LO, 32'h0BAD_F00D);
    MDOp = OP_NONE;
    step();
    check_val("mt_idle_busy", {31'd0, Busy}, 32'd0);
    m_hi = 32'hDEAD_BEEF;
    m_lo = 32'h0BAD_F00D;

    // async reset in the middle of a DIV (third busy cycle)
    Start = 1'b1; MDOp = OP_DIV; A = 32'd100; B = 32'd7;
    step();
    Start = 1'b0; MDOp = OP_NONE;
    check_val("abort_busy_pre", {31'd0, Busy}, 32'd1);
    step();
    step();
    Reset = 1'b1;
    #1;
    check_val("abort_busy", {31'd0, Busy}, 32'd0);
    check_val("abort_hi", HI, 32'd0);
    check_val("abort_lo", LO, 32'd0);
    step();
    Reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    check_val("abort_idle", {31'd0, Busy}, 32'd0);

    // multiply
    run_md("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA);

    // divide
    run_md("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",     OP_DIVU, 32'd7,         32'd2, DC, 32'd1,         32'd3);
    run_md("div_negb", OP_DIV,  32'd7, 32'hFFFF_FFFE, DC, 32'd1,         32'hFFFF_FFFD);
    run_md("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
    run_md("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, DC, 32'd15,       32'h0FFF_FFFF);

    // Start with reserved opcode: no launch
    Start = 1'b1; MDOp = OP_RSVD; A = 32'd9; B = 32'd9;
    step();
    Start = 1'b0; MDOp = OP_NONE;
    check_val("rsvd_busy", {31'd0, Busy}, 32'd0);
    check_val("rsvd_hi", HI, m_hi);
    check_val("rsvd_lo", LO, m_lo);

    // MULT in flight: a DIV start and an MTHI are both ignored
    Start = 1'b1; MDOp = OP_MULT; A = 32'hFFFF_FFFD; B = 32'h1000_0000;
    step();
    Start = 1'b0; MDOp = OP_NONE;
    step();
    Start = 1'b1; MDOp = OP_DIV; A = 32'd100; B = 32'd3;
    step();
    Start = 1'b0; MDOp = OP_MTHI; A = 32'h0000_1234;
    step();
    check_val("ovl_mthi_ign", HI, m_hi);
    MDOp = OP_NONE;
    step();
    check_val("ovl_busy", {31'd0, Busy}, 32'd1);
    step();
    check_val("ovl_done", {31'd0, Busy}, 32'd0);
    check_val("ovl_hi", HI, 32'hFFFF_FFFF);
    check_val("ovl_lo", LO, 32'hD000_0000);
    step();
    check_val("ovl_no_div", {31'd0, Busy}, 32'd0);
    check_val("ovl_hi_keep", HI, 32'hFFFF_FFFF);
    m_hi = 32'hFFFF_FFFF;
    m_lo = 32'hD000_0000;

    // divide by zero
`ifdef MDU_DIV0_GUARD_EN
    Start = 1'b1; MDOp = OP_DIV; A = 32'd5; B = 32'd0;
    step();
    Start = 1'b0; MDOp = OP_NONE;
    check_val("div0_busy", {31'd0, Busy}, 32'd0);
    check_val("div0_flag", {31'd0, DivZero}, 32'd1);
    check_val("div0_hi", HI, m_hi);
    check_val("div0_lo", LO, m_lo);
    step();
    check_val("div0_flag_clr", {31'd0, DivZero}, 32'd0);
    check_val("div0_busy2", {31'd0, Busy}, 32'd0);
    Start = 1'b1; MDOp = OP_DIVU; A = 32'h8000_0001; B = 32'd0;
    step();
    Start = 1'b0; MDOp = OP_NONE;
    check_val("divu0_flag", {31'd0, DivZero}, 32'd1);
    check_val("divu0_busy", {31'd0, Busy}, 32'd0);
    check_val("divu0_lo", LO, m_lo);
    step();
    check_val("divu0_flag_clr", {31'd0, DivZero}, 32'd0);
`else
    run_md("div0",  OP_DIV,  32'd5,         32'd0, DC, 32'd5,         32'hFFFF_FFFF);
    run_md("divu0", OP_DIVU, 32'h8000_0001, 32'd0, DC, 32'h8000_0001, 32'hFFFF_FFFF);
    check_val("div0_flag_tied", {31'd0, DivZero}, 32'd0);
`endif

    // unit still launches normally afterwards
    run_md("mult_end", OP_MULT, 32'd6, 32'd7, MC, 32'd0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
